// File: rtl/mips_mem_pkg.sv
// Shared definitions for the IF/DM memory port arbiter.
package mips_mem_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright; on a tie the
// port that did not win last time is chosen.
module rr_arb2
  import mips_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  // One-hot grant, bit index equals port id.
  always_comb begin
    gnt          = 2'b00;
    gnt[PORT_IF] = req[PORT_IF] & (~req[PORT_DM] | (last == PORT_DM));
    gnt[PORT_DM] = req[PORT_DM] & (~req[PORT_IF] | (last == PORT_IF));
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch port (IF)
// and the data port (DM). One access in flight; every output is a flop.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int ADDRBUS   = 20,
  parameter int MEM_LAT   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IF_REQ,
  input  logic [ADDRBUS-1:0]   IF_ADDR,
  output logic [DATAWIDTH-1:0] IF_RDATA,
  output logic                 IF_ACK,
  input  logic                 DM_REQ,
  input  logic                 DM_WE,
  input  logic [ADDRBUS-1:0]   DM_ADDR,
  input  logic [DATAWIDTH-1:0] DM_WDATA,
  output logic [DATAWIDTH-1:0] DM_RDATA,
  output logic                 DM_ACK,
  output logic [ADDRBUS-1:0]   MEM_ADDR,
  output logic [DATAWIDTH-1:0] MEM_DI,
  input  logic [DATAWIDTH-1:0] MEM_DO,
  output logic                 MEM_OE,
  output logic                 MEM_WE,
  output logic                 BUSY
);
  localparam int            CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [ADDRBUS-1:0]    addr_q, addr_d;
  logic [DATAWIDTH-1:0]  di_q, di_d;
  logic [DATAWIDTH-1:0]  if_rdata_q, if_rdata_d;
  logic [DATAWIDTH-1:0]  dm_rdata_q, dm_rdata_d;
  logic                  oe_q, oe_d;
  logic                  mwe_q, mwe_d;
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic                  busy_q, busy_d;
  logic [1:0]            gnt;

  rr_arb2 u_arb (
    .req  ({DM_REQ, IF_REQ}),
    .last (last_q),
    .gnt  (gnt)
  );

  // Next-state and registered-output logic; strobes/ACKs are computed one
  // cycle ahead so they leave straight from flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    di_d       = di_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    oe_d       = oe_q;
    mwe_d      = mwe_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          port_d  = gnt[PORT_DM];
          last_d  = gnt[PORT_DM];
          we_d    = gnt[PORT_DM] & DM_WE;
          addr_d  = gnt[PORT_DM] ? DM_ADDR : IF_ADDR;
          // IF never writes, so MEM_DI only follows DM grants.
          di_d    = gnt[PORT_DM] ? DM_WDATA : di_q;
          oe_d    = ~(gnt[PORT_DM] & DM_WE);
          mwe_d   = gnt[PORT_DM] & DM_WE;
          cnt_d   = CNT_LOAD;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (port_q == PORT_DM) dm_rdata_d = MEM_DO;
            else                   if_rdata_d = MEM_DO;
          end
          oe_d     = 1'b0;
          mwe_d    = 1'b0;
          if_ack_d = (port_q == PORT_IF);
          dm_ack_d = (port_q == PORT_DM);
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, cleared at once on reset (aborts any access).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= PORT_IF;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      di_q       <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      oe_q       <= 1'b0;
      mwe_q      <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      port_q     <= port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      di_q       <= di_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      oe_q       <= oe_d;
      mwe_q      <= mwe_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign IF_RDATA = if_rdata_q;
  assign IF_ACK   = if_ack_q;
  assign DM_RDATA = dm_rdata_q;
  assign DM_ACK   = dm_ack_q;
  assign MEM_ADDR = addr_q;
  assign MEM_DI   = di_q;
  assign MEM_OE   = oe_q;
  assign MEM_WE   = mwe_q;
  assign BUSY     = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model driven by
// directed and random requests, plus literal expectations for key scenarios.
module tb_mem_port_arbiter;
  localparam int L     = 2;
  localparam int BOUND = 2 * (L + 2);

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IF_REQ = 1'b0, DM_REQ = 1'b0, DM_WE = 1'b0;
  logic [19:0] IF_ADDR = '0, DM_ADDR = '0;
  logic [15:0] DM_WDATA = '0;
  logic [15:0] IF_RDATA, DM_RDATA, MEM_DI, MEM_DO;
  logic [19:0] MEM_ADDR;
  logic        IF_ACK, DM_ACK, MEM_OE, MEM_WE, BUSY;

  mem_port_arbiter #(.DATAWIDTH(16), .ADDRBUS(20), .MEM_LAT(L)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_ACK(IF_ACK),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK),
    .MEM_ADDR(MEM_ADDR), .MEM_DI(MEM_DI), .MEM_DO(MEM_DO),
    .MEM_OE(MEM_OE), .MEM_WE(MEM_WE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // Behavioural memory: combinational read, write applied on the falling edge.
  logic [15:0] mem [256];
  assign MEM_DO = mem[MEM_ADDR[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(negedge CLK);
      if (MEM_WE) mem[MEM_ADDR[7:0]] = MEM_DI;
    end
  end

  // ---------------- main-process counters and checks ----------------
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- compare-process counters and model ----------------
  int c_checks = 0, c_fails = 0;
  task automatic chk_c(input string nm, input logic [31:0] act, input logic [31:0] exp);
    c_checks++;
    if (act !== exp) begin
      c_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  bit          go = 1'b0;
  bit          inited = 1'b0;
  logic [15:0] mm [256];
  bit          m_busy, m_port, m_we, m_last;
  int          m_t;
  logic [19:0] m_addr, e_addr;
  logic [15:0] m_wdata, m_rdata, e_if_rd, e_dm_rd;
  int          w_if, w_dm;

  // Model: a grant decided in idle cycle t occupies the memory for cycles
  // t+1..t+L and acknowledges in t+L+1; everything is derived from that.
  always @(negedge CLK) begin
    logic e_oe, e_we, e_ia, e_da, e_busy;
    int d;
    if (!inited) begin
      for (int i = 0; i < 256; i++) mm[i] = init_val(i);
      inited = 1'b1;
    end
    if (go) begin
      if (!RST) begin
        m_busy = 0; m_last = 0; e_addr = '0; e_if_rd = '0; e_dm_rd = '0;
        w_if = 0; w_dm = 0;
        chk_c("reset_outputs", {IF_ACK, DM_ACK, MEM_OE, MEM_WE, BUSY}, 5'b0);
        chk_c("reset_addr_di", {MEM_ADDR, MEM_DI}, '0);
        chk_c("reset_rdata", {IF_RDATA, DM_RDATA}, '0);
      end else begin
        e_oe = 0; e_we = 0; e_ia = 0; e_da = 0; e_busy = 0;
        d = cyc - m_t;
        if (m_busy) begin
          e_busy = 1;
          if (d <= L) begin
            e_oe = !m_we;
            e_we = m_we;
          end else begin
            if (m_port) e_da = 1; else e_ia = 1;
            if (!m_we) begin
              if (m_port) e_dm_rd = m_rdata; else e_if_rd = m_rdata;
            end
          end
        end
        chk_c("strobes_acks_busy", {MEM_OE, MEM_WE, IF_ACK, DM_ACK, BUSY},
              {e_oe, e_we, e_ia, e_da, e_busy});
        chk_c("mem_addr", MEM_ADDR, e_addr);
        if (e_we) chk_c("mem_di", MEM_DI, m_wdata);
        chk_c("if_rdata", IF_RDATA, e_if_rd);
        chk_c("dm_rdata", DM_RDATA, e_dm_rd);
        chk_c("dual_ack", IF_ACK & DM_ACK, 0);
        chk_c("dual_strobe", MEM_OE & MEM_WE, 0);
        // starvation bound per port
        if (!IF_REQ) w_if = 0;
        else if (IF_ACK) begin chk_c("if_ack_bound", 32'(w_if <= BOUND), 1); w_if = 0; end
        else begin w_if++; if (w_if == BOUND + 1) chk_c("if_starved", w_if, BOUND); end
        if (!DM_REQ) w_dm = 0;
        else if (DM_ACK) begin chk_c("dm_ack_bound", 32'(w_dm <= BOUND), 1); w_dm = 0; end
        else begin w_dm++; if (w_dm == BOUND + 1) chk_c("dm_starved", w_dm, BOUND); end
        // advance the model
        if (m_busy && d == L + 1) m_busy = 0;
        else if (!m_busy && (IF_REQ || DM_REQ)) begin
          m_port  = (IF_REQ && DM_REQ) ? !m_last : DM_REQ;
          m_last  = m_port;
          m_busy  = 1;
          m_t     = cyc;
          m_we    = m_port && DM_WE;
          m_addr  = m_port ? DM_ADDR : IF_ADDR;
          m_wdata = DM_WDATA;
          if (m_we) mm[m_addr[7:0]] = m_wdata;
          else      m_rdata = mm[m_addr[7:0]];
          e_addr  = m_addr;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input bit any, input bit dm, output int at, output bit port,
                          output int n_oe, output int n_we);
    at = -1; port = 0; n_oe = 0; n_we = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (MEM_OE) n_oe++;
      if (MEM_WE) n_we++;
      if ((any || dm) && DM_ACK) begin at = cyc; port = 1; break; end
      if ((any || !dm) && IF_ACK) begin at = cyc; port = 0; break; end
    end
    if (at < 0) chk("ack_timeout", 0, 1);
  endtask

  task automatic do_reset();
    step(); RST = 0;
    step(); step(); RST = 1;
  endtask

  int at, t, n_oe, n_we, acks;
  bit port;
  bit exp_seq [6] = '{1, 0, 1, 0, 1, 0};

  initial begin
    #1 RST = 0;
    #1 go = 1;
    step(); step();
    chk("reset_busy_acks", {BUSY, IF_ACK, DM_ACK, MEM_OE, MEM_WE}, 5'b0);
    step(); RST = 1;

    // IF read of 0x10
    step(); IF_ADDR = 20'h00010; IF_REQ = 1; t = cyc;
    wait_ack(0, 0, at, port, n_oe, n_we);
    chk("if_latency", at - t, 3);
    chk("if_rdata_beef", IF_RDATA, 16'hBEEF);
    chk("if_oe_cycles", n_oe, 2);
    step(); IF_REQ = 0;

    // DM write 0x20 <- 0x1234, then read back
    step(); DM_REQ = 1; DM_WE = 1; DM_ADDR = 20'h00020; DM_WDATA = 16'h1234; t = cyc;
    wait_ack(0, 1, at, port, n_oe, n_we);
    chk("dm_wr_latency", at - t, 3);
    chk("dm_wr_we_cycles", n_we, 2);
    chk("dm_wr_oe_cycles", n_oe, 0);
    step(); DM_WE = 0;
    wait_ack(0, 1, at, port, n_oe, n_we);
    chk("dm_rd_data", DM_RDATA, 16'h1234);
    chk("dm_rd_oe_cycles", n_oe, 2);
    step(); DM_REQ = 0;

    // both held: alternation starting with DM after reset
    do_reset();
    step(); IF_REQ = 1; DM_REQ = 1; IF_ADDR = 20'h00040; DM_ADDR = 20'h00050;
    for (int k = 0; k < 6; k++) begin
      wait_ack(1, 0, at, port, n_oe, n_we);
      chk($sformatf("grant_seq%0d", k), port, exp_seq[k]);
      step(); IF_ADDR = IF_ADDR + 1; DM_ADDR = DM_ADDR + 1;
    end
    IF_REQ = 0; DM_REQ = 0;
    repeat (4) step();

    // reset in the 2nd access cycle of a write
    DM_REQ = 1; DM_WE = 1; DM_ADDR = 20'h00030; DM_WDATA = 16'h5555;
    step(); step();
    chk("pre_abort_we", MEM_WE, 1);
    RST = 0; DM_REQ = 0;
    #1;
    chk("abort_outputs", {MEM_WE, MEM_OE, BUSY, DM_ACK, IF_ACK}, 5'b0);
    chk("abort_addr", MEM_ADDR, 20'h0);
    step(); step(); RST = 1;
    acks = 0;
    repeat (6) begin @(negedge CLK); if (DM_ACK || IF_ACK || BUSY) acks++; end
    chk("abort_no_ack", acks, 0);

    // DM_REQ dropped after one cycle still completes
    step(); DM_REQ = 1; DM_WE = 0; DM_ADDR = 20'h00010; t = cyc;
    step(); DM_REQ = 0;
    wait_ack(0, 1, at, port, n_oe, n_we);
    chk("drop_latency", at - t, 3);
    chk("drop_rdata", DM_RDATA, 16'hBEEF);
    repeat (3) step();

    // random mix
    for (int n = 0; n < 10000; n++) begin
      step();
      if (IF_REQ && IF_ACK) begin
        if ($urandom_range(0, 1) != 0) IF_ADDR = 20'($urandom); else IF_REQ = 0;
      end else if (IF_REQ) begin
        if ($urandom_range(0, 31) == 0) IF_REQ = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        IF_REQ = 1; IF_ADDR = 20'($urandom);
      end
      if (DM_REQ && DM_ACK) begin
        if ($urandom_range(0, 1) != 0) begin
          DM_ADDR = 20'($urandom); DM_WE = 1'($urandom); DM_WDATA = 16'($urandom);
        end else DM_REQ = 0;
      end else if (DM_REQ) begin
        if ($urandom_range(0, 31) == 0) DM_REQ = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        DM_REQ = 1; DM_ADDR = 20'($urandom); DM_WE = 1'($urandom); DM_WDATA = 16'($urandom);
      end
    end
    IF_REQ = 0; DM_REQ = 0;
    repeat (10) step();

    checks   = checks + c_checks;
    failures = failures + c_fails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
